// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the IF requester, LS requester and data-memory port
// signals that meet at the memory arbiter.
//   slave  : the arbiter's view (takes requests and memory responses, drives
//            grants, completions and the memory request).
//   master : the view of whoever drives the requests and models the memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   // Instruction-fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;

   // Load/store requester
   logic              ls_req;
   logic              ls_wen;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic [3:0]        ls_wlen;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   // Shared data-memory port
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic              mem_ren;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_wlen;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_wen, ls_addr, ls_wdata, ls_wlen,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_req, mem_addr, mem_wen, mem_ren, mem_wdata, mem_wlen,
      input  mem_ack, mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_wen, ls_addr, ls_wdata, ls_wlen,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_req, mem_addr, mem_wen, mem_ren, mem_wdata, mem_wlen,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data-memory port between instruction fetch
// (IF) and load/store (LS). A winning request is captured into registers that
// drive the memory port unchanged until mem_ack. The owner then gets a
// one-cycle rvalid pulse carrying the read data.
//
// Optional build macro MEM_ARB_RR_EN: when both requesters ask in the same
// IDLE cycle, the one that did not win last time is granted. Without it, LS
// always wins a tie. Uncontended behaviour is the same in both builds.
module mem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic         clk,
   input  logic         rstn,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_e;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_LS = 1'b1
   } owner_e;

   state_e            state_q, state_d;
   owner_e            lastOwner_q, lastOwner_d;

   logic              memReq_q, memReq_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic              memWen_q, memWen_d;
   logic              memRen_q, memRen_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [3:0]        memWlen_q, memWlen_d;

   logic              ifRvalid_q, ifRvalid_d;
   logic [31:0]       ifRdata_q, ifRdata_d;
   logic              lsRvalid_q, lsRvalid_d;
   logic [DATA_W-1:0] lsRdata_q, lsRdata_d;

   logic              grantIf;
   logic              grantLs;

   // Grant decision: only in IDLE and never while reset is being applied, so
   // a request cannot be granted on an edge that discards it. At most one
   // grant is raised; a tie goes to LS, or alternates with MEM_ARB_RR_EN.
   always_comb begin
      grantIf = 1'b0;
      grantLs = 1'b0;
      if (rstn && (state_q == IDLE)) begin
         if (bus.if_req && bus.ls_req) begin
`ifdef MEM_ARB_RR_EN
            if (lastOwner_q == OWNER_IF) begin
               grantLs = 1'b1;
            end else begin
               grantIf = 1'b1;
            end
`else
            grantLs = 1'b1;
`endif
         end else begin
            grantIf = bus.if_req;
            grantLs = bus.ls_req;
         end
      end
   end

   // Next-state logic. A grant captures the winner's fields straight into the
   // memory-port registers, which then hold until mem_ack. On mem_ack the
   // port returns to all-zero, the owner's rdata is updated and its rvalid is
   // raised for the following cycle. mem_ack seen in IDLE falls through the
   // defaults and changes nothing.
   always_comb begin
      state_d     = state_q;
      lastOwner_d = lastOwner_q;
      memReq_d    = memReq_q;
      memAddr_d   = memAddr_q;
      memWen_d    = memWen_q;
      memRen_d    = memRen_q;
      memWdata_d  = memWdata_q;
      memWlen_d   = memWlen_q;
      ifRvalid_d  = 1'b0;
      ifRdata_d   = ifRdata_q;
      lsRvalid_d  = 1'b0;
      lsRdata_d   = lsRdata_q;

      case (state_q)
         IDLE: begin
            if (grantLs) begin
               state_d     = BUSY_LS;
               lastOwner_d = OWNER_LS;
               memReq_d    = 1'b1;
               memAddr_d   = bus.ls_addr;
               memWen_d    = bus.ls_wen;
               memRen_d    = ~bus.ls_wen;
               memWdata_d  = bus.ls_wdata;
               memWlen_d   = bus.ls_wlen;
            end else if (grantIf) begin
               state_d     = BUSY_IF;
               lastOwner_d = OWNER_IF;
               memReq_d    = 1'b1;
               memAddr_d   = bus.if_addr;
               memWen_d    = 1'b0;
               memRen_d    = 1'b1;
               memWdata_d  = '0;
               memWlen_d   = '0;
            end
         end

         BUSY_IF: begin
            if (bus.mem_ack) begin
               state_d    = IDLE;
               memReq_d   = 1'b0;
               memAddr_d  = '0;
               memWen_d   = 1'b0;
               memRen_d   = 1'b0;
               memWdata_d = '0;
               memWlen_d  = '0;
               ifRvalid_d = 1'b1;
               // Bit 2 of the fetch address selects which 32-bit half of the
               // 64-bit memory word holds the instruction.
               ifRdata_d  = memAddr_q[2] ? bus.mem_rdata[63:32]
                                         : bus.mem_rdata[31:0];
            end
         end

         BUSY_LS: begin
            if (bus.mem_ack) begin
               state_d    = IDLE;
               memReq_d   = 1'b0;
               memAddr_d  = '0;
               memWen_d   = 1'b0;
               memRen_d   = 1'b0;
               memWdata_d = '0;
               memWlen_d  = '0;
               lsRvalid_d = 1'b1;
               lsRdata_d  = memWen_q ? '0 : bus.mem_rdata;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset abandons any access in flight, so
   // a mem_ack arriving afterwards lands in IDLE and is ignored.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         lastOwner_q <= OWNER_IF;
         memReq_q    <= 1'b0;
         memAddr_q   <= '0;
         memWen_q    <= 1'b0;
         memRen_q    <= 1'b0;
         memWdata_q  <= '0;
         memWlen_q   <= '0;
         ifRvalid_q  <= 1'b0;
         ifRdata_q   <= '0;
         lsRvalid_q  <= 1'b0;
         lsRdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         lastOwner_q <= lastOwner_d;
         memReq_q    <= memReq_d;
         memAddr_q   <= memAddr_d;
         memWen_q    <= memWen_d;
         memRen_q    <= memRen_d;
         memWdata_q  <= memWdata_d;
         memWlen_q   <= memWlen_d;
         ifRvalid_q  <= ifRvalid_d;
         ifRdata_q   <= ifRdata_d;
         lsRvalid_q  <= lsRvalid_d;
         lsRdata_q   <= lsRdata_d;
      end
   end

   // Consistency guard: the busy state always names the requester that was
   // recorded as the last owner, since both are written on the same grant.
   always_ff @(posedge clk) begin
      if (rstn && (state_q != IDLE)) begin
         assert ((state_q == BUSY_LS) == (lastOwner_q == OWNER_LS));
      end
   end

   assign bus.if_gnt    = grantIf;
   assign bus.ls_gnt    = grantLs;
   assign bus.if_rvalid = ifRvalid_q;
   assign bus.if_rdata  = ifRdata_q;
   assign bus.ls_rvalid = lsRvalid_q;
   assign bus.ls_rdata  = lsRdata_q;
   assign bus.mem_req   = memReq_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_wen   = memWen_q;
   assign bus.mem_ren   = memRen_q;
   assign bus.mem_wdata = memWdata_q;
   assign bus.mem_wlen  = memWlen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test for mem_arbiter. The stimulus process drives
// requests and memory acks cycle by cycle and queues the expected memory
// accesses and completions. A separate monitor pops and compares whenever the
// DUT starts a memory access or raises an rvalid. Define MEM_ARB_RR_EN to
// also run the round-robin tie sequence.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   logic clk;
   logic rstn;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic        ren;
      logic [63:0] wdata;
      logic [3:0]  wlen;
   } access_t;

   access_t     accQ[$];
   access_t     curAcc;
   logic [31:0] ifQ[$];
   logic [63:0] lsQ[$];

   int   checks = 0;
   int   errors = 0;
   logic monitorOn = 1'b0;
   logic prevMemReq = 1'b0;
   logic prevIfRvalid = 1'b0;
   logic prevLsRvalid = 1'b0;

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [63:0] ifAddr,
                                input logic lsReq, input logic lsWen,
                                input logic [63:0] lsAddr, input logic [63:0] lsWdata,
                                input logic [3:0] lsWlen);
      bus.if_req   = ifReq;
      bus.if_addr  = ifAddr;
      bus.ls_req   = lsReq;
      bus.ls_wen   = lsWen;
      bus.ls_addr  = lsAddr;
      bus.ls_wdata = lsWdata;
      bus.ls_wlen  = lsWlen;
   endtask

   task automatic memDrive(input logic ack, input logic [63:0] data);
      bus.mem_ack   = ack;
      bus.mem_rdata = data;
   endtask

   task automatic expectAccess(input logic [63:0] addr, input logic wen, input logic ren,
                               input logic [63:0] wdata, input logic [3:0] wlen);
      access_t a;
      a.addr  = addr;
      a.wen   = wen;
      a.ren   = ren;
      a.wdata = wdata;
      a.wlen  = wlen;
      accQ.push_back(a);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: on the falling edge, match each new memory access and each
   // rvalid pulse against the queued expectations, and check that the port
   // is quiet and grants are exclusive the rest of the time.
   always @(negedge clk) begin
      if (monitorOn) begin
         checkOutput("gnt_exclusive", 64'(bus.if_gnt & bus.ls_gnt), 64'd0);
         if (bus.mem_req && !prevMemReq) begin
            checkOutput("mem_access_queued", 64'(accQ.size() != 0), 64'd1);
            if (accQ.size() != 0) curAcc = accQ.pop_front();
         end
         if (bus.mem_req) begin
            checkOutput("mem_addr", bus.mem_addr, curAcc.addr);
            checkOutput("mem_wen", 64'(bus.mem_wen), 64'(curAcc.wen));
            checkOutput("mem_ren", 64'(bus.mem_ren), 64'(curAcc.ren));
            checkOutput("mem_wdata", bus.mem_wdata, curAcc.wdata);
            checkOutput("mem_wlen", 64'(bus.mem_wlen), 64'(curAcc.wlen));
         end else begin
            checkOutput("mem_idle_quiet",
                        64'({bus.mem_wen, bus.mem_ren, bus.mem_wlen,
                             |bus.mem_addr, |bus.mem_wdata}), 64'd0);
         end
         if (bus.if_rvalid) begin
            checkOutput("if_rvalid_width", 64'(prevIfRvalid), 64'd0);
            checkOutput("if_rvalid_queued", 64'(ifQ.size() != 0), 64'd1);
            if (ifQ.size() != 0) checkOutput("if_rdata", 64'(bus.if_rdata), 64'(ifQ.pop_front()));
         end
         if (bus.ls_rvalid) begin
            checkOutput("ls_rvalid_width", 64'(prevLsRvalid), 64'd0);
            checkOutput("ls_rvalid_queued", 64'(lsQ.size() != 0), 64'd1);
            if (lsQ.size() != 0) checkOutput("ls_rdata", bus.ls_rdata, lsQ.pop_front());
         end
         prevMemReq   = bus.mem_req;
         prevIfRvalid = bus.if_rvalid;
         prevLsRvalid = bus.ls_rvalid;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus
   initial begin
`ifdef MEM_ARB_RR_EN
      logic        rrWinLs;
      logic [63:0] rrData;
`endif
      rstn = 1'b0;
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b0, 64'd0);
      repeat (2) tick();
      sample();
      monitorOn = 1'b1;
      checkOutput("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
      checkOutput("rst_ls_gnt", 64'(bus.ls_gnt), 64'd0);
      checkOutput("rst_mem_req", 64'(bus.mem_req), 64'd0);
      checkOutput("rst_mem_addr", bus.mem_addr, 64'd0);
      checkOutput("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
      checkOutput("rst_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
      checkOutput("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
      checkOutput("rst_ls_rdata", bus.ls_rdata, 64'd0);
      tick();
      rstn = 1'b1;

      // Single fetch, ack two cycles after mem_req rises
      applyStimulus(1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      expectAccess(64'h8000_0004, 1'b0, 1'b1, 64'd0, 4'd0);
      ifQ.push_back(32'h1111_1111);
      sample();
      checkOutput("fetch_if_gnt", 64'(bus.if_gnt), 64'd1);
      checkOutput("fetch_ls_gnt", 64'(bus.ls_gnt), 64'd0);
      tick();
      applyStimulus(1'b0, 64'hFFFF_0000_0000_0000, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      sample();
      checkOutput("fetch_mem_req_t1", 64'(bus.mem_req), 64'd1);
      tick();
      sample();
      checkOutput("fetch_mem_req_t2", 64'(bus.mem_req), 64'd1);
      tick();
      memDrive(1'b1, 64'h1111_1111_2222_2222);
      sample();
      checkOutput("fetch_mem_req_t3", 64'(bus.mem_req), 64'd1);
      checkOutput("fetch_no_early_rvalid", 64'(bus.if_rvalid), 64'd0);
      tick();
      memDrive(1'b0, 64'h0000_0000_0000_DEAD);
      sample();
      checkOutput("fetch_if_rvalid_t4", 64'(bus.if_rvalid), 64'd1);
      checkOutput("fetch_mem_req_t4", 64'(bus.mem_req), 64'd0);
      tick();
      sample();
      checkOutput("fetch_if_rvalid_t5", 64'(bus.if_rvalid), 64'd0);
      checkOutput("fetch_if_rdata_hold", 64'(bus.if_rdata), 64'h1111_1111);

      // Store with zero-wait ack, then a load of the same address granted in
      // the store's rvalid cycle
      tick();
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 4'hF);
      expectAccess(64'h8000_1000, 1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 4'hF);
      lsQ.push_back(64'd0);
      sample();
      checkOutput("store_ls_gnt", 64'(bus.ls_gnt), 64'd1);
      checkOutput("store_if_gnt", 64'(bus.if_gnt), 64'd0);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b1, 64'h0123_4567_89AB_CDEF);
      sample();
      checkOutput("store_mem_wen", 64'(bus.mem_wen), 64'd1);
      tick();
      memDrive(1'b0, 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'h8000_1000, 64'd0, 4'd0);
      expectAccess(64'h8000_1000, 1'b0, 1'b1, 64'd0, 4'd0);
      lsQ.push_back(64'hDEAD_BEEF_CAFE_F00D);
      sample();
      checkOutput("store_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);
      checkOutput("store_ls_rdata", bus.ls_rdata, 64'd0);
      checkOutput("load_gnt_in_rvalid_cycle", 64'(bus.ls_gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b1, 64'hDEAD_BEEF_CAFE_F00D);
      sample();
      checkOutput("load_mem_ren", 64'(bus.mem_ren), 64'd1);
      tick();
      memDrive(1'b0, 64'd0);
      sample();
      checkOutput("load_ls_rdata", bus.ls_rdata, 64'hDEAD_BEEF_CAFE_F00D);

      // Simultaneous requests: LS first, IF granted in the ls_rvalid cycle
      tick();
      applyStimulus(1'b1, 64'h8000_0020, 1'b1, 1'b0, 64'h8000_4000, 64'd0, 4'd0);
      expectAccess(64'h8000_4000, 1'b0, 1'b1, 64'd0, 4'd0);
      lsQ.push_back(64'h4444_4444_5555_5555);
      sample();
      checkOutput("tie_ls_gnt", 64'(bus.ls_gnt), 64'd1);
      checkOutput("tie_if_gnt", 64'(bus.if_gnt), 64'd0);
      tick();
      applyStimulus(1'b1, 64'h8000_0020, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b1, 64'h4444_4444_5555_5555);
      sample();
      checkOutput("tie_if_blocked", 64'(bus.if_gnt), 64'd0);
      tick();
      memDrive(1'b0, 64'd0);
      expectAccess(64'h8000_0020, 1'b0, 1'b1, 64'd0, 4'd0);
      ifQ.push_back(32'h7777_7777);
      sample();
      checkOutput("tie_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);
      checkOutput("tie_if_gnt_late", 64'(bus.if_gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b1, 64'h6666_6666_7777_7777);
      sample();
      tick();
      memDrive(1'b0, 64'd0);
      sample();
      checkOutput("tie_if_rdata", 64'(bus.if_rdata), 64'h7777_7777);

`ifdef MEM_ARB_RR_EN
      // Three back-to-back ties after an IF grant: LS, IF, LS
      for (int k = 0; k < 3; k++) begin
         rrWinLs = (k != 1);
         rrData  = 64'h1000_0000_2000_0000 + 64'(k);
         tick();
         memDrive(1'b0, 64'd0);
         applyStimulus(1'b1, 64'h8000_0104, 1'b1, 1'b0, 64'h8000_3000, 64'd0, 4'd0);
         if (rrWinLs) begin
            expectAccess(64'h8000_3000, 1'b0, 1'b1, 64'd0, 4'd0);
            lsQ.push_back(rrData);
         end else begin
            expectAccess(64'h8000_0104, 1'b0, 1'b1, 64'd0, 4'd0);
            ifQ.push_back(32'h1000_0000);
         end
         sample();
         checkOutput("rr_ls_gnt", 64'(bus.ls_gnt), 64'(rrWinLs));
         checkOutput("rr_if_gnt", 64'(bus.if_gnt), 64'(!rrWinLs));
         tick();
         applyStimulus(!rrWinLs, 64'h8000_0104, rrWinLs, 1'b0, 64'h8000_3000, 64'd0, 4'd0);
         memDrive(1'b1, rrData);
         sample();
      end
      tick();
      memDrive(1'b0, 64'd0);
      applyStimulus(1'b1, 64'h8000_0104, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      expectAccess(64'h8000_0104, 1'b0, 1'b1, 64'd0, 4'd0);
      ifQ.push_back(32'h3000_0000);
      sample();
      checkOutput("rr_if_after_ties", 64'(bus.if_gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b1, 64'h3000_0000_4000_0000);
      sample();
      tick();
      memDrive(1'b0, 64'd0);
      sample();
`endif

      // Busy blocking: LS waits out a fetch whose ack is delayed
      tick();
      applyStimulus(1'b1, 64'h8000_0010, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      expectAccess(64'h8000_0010, 1'b0, 1'b1, 64'd0, 4'd0);
      ifQ.push_back(32'hBBBB_BBBB);
      sample();
      checkOutput("busy_if_gnt", 64'(bus.if_gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'h8000_2000, 64'd0, 4'd0);
      for (int c = 0; c < 5; c++) begin
         sample();
         checkOutput("busy_ls_gnt_blocked", 64'(bus.ls_gnt), 64'd0);
         checkOutput("busy_mem_addr_stable", bus.mem_addr, 64'h8000_0010);
         tick();
      end
      memDrive(1'b1, 64'hAAAA_AAAA_BBBB_BBBB);
      sample();
      checkOutput("busy_ls_gnt_ack_cycle", 64'(bus.ls_gnt), 64'd0);
      tick();
      memDrive(1'b0, 64'd0);
      expectAccess(64'h8000_2000, 1'b0, 1'b1, 64'd0, 4'd0);
      lsQ.push_back(64'h1234_5678_9ABC_DEF0);
      sample();
      checkOutput("busy_if_rvalid", 64'(bus.if_rvalid), 64'd1);
      checkOutput("busy_ls_gnt_released", 64'(bus.ls_gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b1, 64'h1234_5678_9ABC_DEF0);
      sample();
      tick();
      memDrive(1'b0, 64'd0);
      sample();
      checkOutput("busy_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);

      // Reset in the middle of a store; a late ack must be ignored
      tick();
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 64'h8000_5000, 64'h5555, 4'h3);
      expectAccess(64'h8000_5000, 1'b1, 1'b0, 64'h5555, 4'h3);
      sample();
      checkOutput("rstmid_ls_gnt", 64'(bus.ls_gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      sample();
      checkOutput("rstmid_busy", 64'(bus.mem_req), 64'd1);
      tick();
      rstn = 1'b0;
      sample();
      tick();
      rstn = 1'b1;
      memDrive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      sample();
      checkOutput("rstmid_mem_req", 64'(bus.mem_req), 64'd0);
      checkOutput("rstmid_mem_wen", 64'(bus.mem_wen), 64'd0);
      checkOutput("rstmid_mem_addr", bus.mem_addr, 64'd0);
      checkOutput("rstmid_ls_rdata", bus.ls_rdata, 64'd0);
      checkOutput("rstmid_if_rdata", 64'(bus.if_rdata), 64'd0);
      tick();
      memDrive(1'b0, 64'd0);
      sample();
      checkOutput("rstmid_no_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
      checkOutput("rstmid_idle", 64'(bus.mem_req), 64'd0);

      // Stray ack in IDLE, then a fetch proves the arbiter is still idle
      tick();
      memDrive(1'b1, 64'hCAFE_CAFE_CAFE_CAFE);
      sample();
      tick();
      memDrive(1'b0, 64'd0);
      sample();
      checkOutput("stray_if_rvalid", 64'(bus.if_rvalid), 64'd0);
      checkOutput("stray_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
      checkOutput("stray_mem_req", 64'(bus.mem_req), 64'd0);
      tick();
      applyStimulus(1'b1, 64'h8000_000C, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      expectAccess(64'h8000_000C, 1'b0, 1'b1, 64'd0, 4'd0);
      ifQ.push_back(32'h89AB_CDEF);
      sample();
      checkOutput("stray_then_if_gnt", 64'(bus.if_gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      memDrive(1'b1, 64'h89AB_CDEF_0123_4567);
      sample();
      tick();
      memDrive(1'b0, 64'd0);
      sample();
      checkOutput("stray_then_if_rdata", 64'(bus.if_rdata), 64'h89AB_CDEF);

      repeat (2) tick();
      sample();
      checkOutput("acc_queue_drained", 64'(accQ.size()), 64'd0);
      checkOutput("if_queue_drained", 64'(ifQ.size()), 64'd0);
      checkOutput("ls_queue_drained", 64'(lsQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port (addr/wdata/wlen/wen/ren/rdata) between the instruction-fetch requester (IF) and the load/store requester (LS) of the pipeline.
- Arbitrates between the two and registers the winning request onto the memory port.
- Holds the request stable until the memory acknowledges it, then returns the read data to the owner with a one-cycle valid pulse.
- Sits between ifu/mmu and the memory model; replaces direct combinational mm_* hookup.

Parameters:
ADDR_W, 64, address width of all address ports
DATA_W, 64, memory data width; IF data is fixed at 32 bits

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
if_req  in  1  IF read request; held until if_gnt
if_addr  in  ADDR_W  IF fetch address, 4-byte aligned
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction
ls_req  in  1  LS request; held until ls_gnt
ls_wen  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  LS address
ls_wdata  in  DATA_W  store data
ls_wlen  in  4  store byte mask/length, forwarded unchanged
ls_gnt  out  1  LS request accepted this cycle
ls_rvalid  out  1  one-cycle pulse: LS access complete (load or store)
ls_rdata  out  DATA_W  load data; 0 for stores
mem_req  out  1  memory access in progress
mem_addr  out  ADDR_W  memory address
mem_wen  out  1  write enable
mem_ren  out  1  read enable
mem_wdata  out  DATA_W  write data
mem_wlen  out  4  write length/mask
mem_ack  in  1  one-cycle pulse: access done, mem_rdata valid
mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (rstn low at a posedge) values: state IDLE; every output 0; last_owner = IF.
- Reset mid-access: access is abandoned with no rvalid; a later mem_ack is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- Grants:
  - if_gnt and ls_gnt are combinational and asserted only in IDLE.
  - At most one grant is high per cycle.
- Fixed priority: LS wins when both request.
- IDLE transitions: on the granted edge, request fields are captured into registers and the FSM moves to BUSY_IF or BUSY_LS.
- BUSY_IF memory outputs:
  - mem_req=1, mem_ren=1, mem_wen=0, mem_wlen=0, mem_wdata=0.
  - mem_addr = the captured if_addr.
- BUSY_LS memory outputs:
  - mem_req=1, mem_ren=!wen, mem_wen=wen.
  - mem_addr, mem_wdata and mem_wlen come from the captured LS fields.
- All mem_* outputs are registered and stay stable for the whole busy period, regardless of requester inputs.
- In IDLE, all mem_* outputs are 0.
- On mem_ack in a BUSY state:
  - Next cycle: the owner's rvalid pulses for exactly 1 cycle, mem_req drops to 0, and the FSM is in IDLE.
  - BUSY_IF: if_rdata = mem_rdata[63:32] if captured addr[2]=1, else mem_rdata[31:0].
  - BUSY_LS load: ls_rdata = mem_rdata. BUSY_LS store: ls_rdata = 0.
  - rdata outputs hold their value until the next completion for the same owner.
- mem_ack received in IDLE is ignored.
- Latency:
  - Grant at cycle T, mem_req high at T+1.
  - With mem_ack at T+1+N, rvalid is at T+2+N.
  - The next grant is possible in the rvalid cycle, so the minimum spacing between back-to-back accesses is 2 cycles.
- Requests raised while BUSY get no grant; the requester keeps req high.
- After its grant, a requester may drop req or change its fields freely.
- last_owner is updated on every grant; it is used only with the optional feature.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on a tie. When if_req and ls_req are both high in IDLE, the requester that is not last_owner is granted. With last_owner=IF after reset, the first tie goes to LS.
- Undefined: fixed LS priority; last_owner exists but does not affect the grant.
- The behaviour with no conflicting requests is identical in both builds.

Test Plan:
- Single fetch: if_req=1, if_addr=0x80000004, mem_ack 2 cycles after mem_req, mem_rdata=0x11111111_22222222 -> if_gnt at T, mem_req T+1..T+3, mem_addr=0x80000004, if_rvalid one pulse at T+4, if_rdata=0x11111111.
- Store then load, same address: ls_req, ls_wen=1, ls_addr=0x80001000, ls_wdata=0xDEADBEEF_CAFEF00D, ls_wlen=0xF, zero-wait ack -> mem_wen=1, mem_wlen=0xF, ls_rvalid pulse, ls_rdata=0. Then a load from the same address with mem_rdata returning the stored value -> mem_ren=1, ls_rdata=0xDEADBEEF_CAFEF00D.
- Simultaneous: if_req=ls_req=1 at the same edge.
  - Default build: LS granted first; IF granted in the cycle of ls_rvalid.
  - MEM_ARB_RR_EN build: three consecutive ties grant LS, IF, LS.
- Busy blocking: ls_req raised while BUSY_IF with mem_ack delayed 5 cycles -> ls_gnt=0 throughout; mem_addr unchanged; ls_gnt=1 in the if_rvalid cycle.
- Reset mid-access: rstn=0 for one cycle while BUSY_LS, then mem_ack -> no ls_rvalid; all outputs 0; FSM in IDLE.
- Stray ack: mem_ack=1 in IDLE -> no rvalid; state unchanged.
